// File: rtl/calc_key_seq.sv
// calc_key_seq: key conditioning and sequencing for the single-digit
// add/subtract display calculator.
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   key3, key2, key0   raw active-low pushbuttons (A+1, B+1, calculate)
//   cal                operation switch, 1 = plus, 0 = minus
//   dig6, dig4         operand A / operand B digit codes (0..9)
//   dig2, dig1         result tens/sign and units codes (10 = blank, 11 = minus)
//   done               one-cycle pulse when a new result is shown
//   state_o            FSM state (EDIT=0, CALC=1, SHOW=2)
//
// Optional feature macro: CALC_LIVE_UPDATE_EN
//   When defined, operand presses and cal changes in SHOW trigger a recompute
//   instead of returning to EDIT.
module calc_key_seq #(
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned DEB_W      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key3,
    input  logic       key2,
    input  logic       key0,
    input  logic       cal,
    output logic [3:0] dig6,
    output logic [3:0] dig4,
    output logic [3:0] dig2,
    output logic [3:0] dig1,
    output logic       done,
    output logic [1:0] state_o
);

    localparam int unsigned NKEYS = 3;
    localparam logic [3:0]  BLANK = 4'd10;
    localparam logic [3:0]  MINUS = 4'd11;

    typedef enum logic [1:0] {
        EDIT = 2'd0,
        CALC = 2'd1,
        SHOW = 2'd2
    } state_t;

    // Key vector index: 2 = key3, 1 = key2, 0 = key0
    logic [NKEYS-1:0] keys;
    logic [NKEYS-1:0] sync1;
    logic [NKEYS-1:0] sync2;
    logic [NKEYS-1:0] deb;
    logic [NKEYS-1:0] armed;
    logic [NKEYS-1:0] press;
    logic [DEB_W-1:0] cnt [NKEYS];
    logic [1:0]       warm;

    logic cal_s1;
    logic cal_s2;
    logic op;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] a_nxt;
    logic [3:0] b_nxt;
    logic [3:0] dig2_nxt;
    logic [3:0] dig1_nxt;
    logic       done_nxt;
    logic       op_nxt;
    logic [4:0] sum;

    assign keys    = {key3, key2, key0};
    assign state_o = state;

    function automatic logic [3:0] inc9(input logic [3:0] v);
        return (v == 4'd9) ? 4'd0 : v + 4'd1;
    endfunction

    // Synchronise, debounce and edge-detect the three keys.
    // A key is only armed once it has been seen released after the
    // synchroniser refilled, so a key held through reset yields no press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
            deb   <= '1;
            armed <= '0;
            press <= '0;
            warm  <= '0;
            for (int i = 0; i < NKEYS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= keys;
            sync2 <= sync1;
            warm  <= {warm[0], 1'b1};
            for (int i = 0; i < NKEYS; i++) begin
                press[i] <= 1'b0;
                armed[i] <= armed[i] | (warm[1] & sync2[i] & deb[i]);
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
                    deb[i]   <= sync2[i];
                    cnt[i]   <= '0;
                    press[i] <= armed[i] & ~sync2[i];
                end else begin
                    cnt[i] <= cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    // Operation switch synchroniser.
    always_ff @(posedge clk) begin
        if (rst) begin
            cal_s1 <= 1'b1;
            cal_s2 <= 1'b1;
        end else begin
            cal_s1 <= cal;
            cal_s2 <= cal_s1;
        end
    end

`ifdef CALC_LIVE_UPDATE_EN
    logic cal_prev;
    logic cal_chg;

    // Detect any change of the synchronised operation switch.
    always_ff @(posedge clk) begin
        if (rst) begin
            cal_prev <= 1'b1;
        end else begin
            cal_prev <= cal_s2;
        end
    end

    assign cal_chg = cal_s2 ^ cal_prev;
`endif

    // State and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EDIT;
            dig6  <= 4'd0;
            dig4  <= 4'd0;
            dig2  <= BLANK;
            dig1  <= BLANK;
            done  <= 1'b0;
            op    <= 1'b1;
        end else begin
            state <= state_nxt;
            dig6  <= a_nxt;
            dig4  <= b_nxt;
            dig2  <= dig2_nxt;
            dig1  <= dig1_nxt;
            done  <= done_nxt;
            op    <= op_nxt;
        end
    end

    // Next-state, operand update and result computation.
    always_comb begin
        state_nxt = state;
        a_nxt     = press[2] ? inc9(dig6) : dig6;
        b_nxt     = press[1] ? inc9(dig4) : dig4;
        dig2_nxt  = dig2;
        dig1_nxt  = dig1;
        done_nxt  = 1'b0;
        op_nxt    = op;
        sum       = 5'({1'b0, dig6}) + 5'({1'b0, dig4});

        case (state)
            EDIT: begin
                if (press[0]) begin
                    state_nxt = CALC;
                    op_nxt    = cal_s2;
                end
            end
            CALC: begin
                state_nxt = SHOW;
                done_nxt  = 1'b1;
                if (op) begin
                    if (sum >= 5'd10) begin
                        dig2_nxt = 4'd1;
                        dig1_nxt = 4'(sum - 5'd10);
                    end else begin
                        dig2_nxt = BLANK;
                        dig1_nxt = 4'(sum);
                    end
                end else if (dig6 >= dig4) begin
                    dig2_nxt = BLANK;
                    dig1_nxt = dig6 - dig4;
                end else begin
                    dig2_nxt = MINUS;
                    dig1_nxt = dig4 - dig6;
                end
            end
            SHOW: begin
`ifdef CALC_LIVE_UPDATE_EN
                if (press[0]) begin
                    state_nxt = CALC;
                    op_nxt    = cal_s2;
                end else if (press[2] | press[1]) begin
                    state_nxt = CALC;
                end else if (cal_chg) begin
                    state_nxt = CALC;
                    op_nxt    = cal_s2;
                end
`else
                if (press[0]) begin
                    state_nxt = CALC;
                    op_nxt    = cal_s2;
                end else if (press[2] | press[1]) begin
                    state_nxt = EDIT;
                    dig2_nxt  = BLANK;
                    dig1_nxt  = BLANK;
                end
`endif
            end
            default: begin
                state_nxt = EDIT;
            end
        endcase
    end

endmodule

// File: tb/tb_calc_key_seq.sv
// Directed testbench for calc_key_seq with DEB_CYCLES = 4.
module tb_calc_key_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       key3;
    logic       key2;
    logic       key0;
    logic       cal;
    logic [3:0] dig6;
    logic [3:0] dig4;
    logic [3:0] dig2;
    logic [3:0] dig1;
    logic       done;
    logic [1:0] state_o;

    int total    = 0;
    int bad      = 0;
    int done_cnt = 0;

    calc_key_seq #(
        .DEB_CYCLES(4),
        .DEB_W     (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .key3   (key3),
        .key2   (key2),
        .key0   (key0),
        .cal    (cal),
        .dig6   (dig6),
        .dig4   (dig4),
        .dig2   (dig2),
        .dig1   (dig1),
        .done   (done),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_key(input int idx, input logic v);
        case (idx)
            3:       key3 = v;
            2:       key2 = v;
            default: key0 = v;
        endcase
    endtask

    task automatic press_key(input int idx);
        set_key(idx, 1'b0);
        repeat (12) tick();
        set_key(idx, 1'b1);
        repeat (12) tick();
    endtask

    // key0 press with exact latency check: sync (2) + debounce (4) -> press
    // pulse after edge 6, CALC after edge 7, result and done after edge 8.
    task automatic calc_timed(input string tag, input int e2, input int e1);
        int d0;
        d0   = done_cnt;
        key0 = 1'b0;
        repeat (7) tick();
        chk({tag, "_pre_done"}, int'(done), 0);
        chk({tag, "_calc_state"}, int'(state_o), 1);
        tick();
        chk({tag, "_done"}, int'(done), 1);
        chk({tag, "_dig2"}, int'(dig2), e2);
        chk({tag, "_dig1"}, int'(dig1), e1);
        tick();
        chk({tag, "_post_done"}, int'(done), 0);
        chk({tag, "_show_state"}, int'(state_o), 2);
        repeat (4) tick();
        key0 = 1'b1;
        repeat (12) tick();
        chk({tag, "_done_count"}, done_cnt - d0, 1);
    endtask

    initial begin
        int d0;
        rst  = 1'b1;
        key3 = 1'b1;
        key2 = 1'b1;
        key0 = 1'b1;
        cal  = 1'b1;
        repeat (3) tick();
        chk("rst_dig6", int'(dig6), 0);
        chk("rst_dig4", int'(dig4), 0);
        chk("rst_dig2", int'(dig2), 10);
        chk("rst_dig1", int'(dig1), 10);
        chk("rst_done", int'(done), 0);
        chk("rst_state", int'(state_o), 0);
        rst = 1'b0;
        repeat (3) tick();

        // 4 + 5 = 9
        repeat (4) press_key(3);
        repeat (5) press_key(2);
        chk("a4", int'(dig6), 4);
        chk("b5", int'(dig4), 5);
        calc_timed("sum9", 10, 9);

        // A = 7, B = 8: plus then minus
        repeat (3) press_key(3);
        repeat (3) press_key(2);
        chk("a7", int'(dig6), 7);
        chk("b8", int'(dig4), 8);
        calc_timed("sum15", 1, 5);
        cal = 1'b0;
        repeat (10) tick();
        calc_timed("diff_neg", 11, 1);

        // B wraps 8 -> 9 -> 0
        press_key(2);
        press_key(2);
        chk("b_wrap", int'(dig4), 0);
`ifdef CALC_LIVE_UPDATE_EN
        chk("wrap_state", int'(state_o), 2);
        chk("wrap_dig2", int'(dig2), 10);
        chk("wrap_dig1", int'(dig1), 7);
`else
        chk("wrap_state", int'(state_o), 0);
        chk("wrap_dig2", int'(dig2), 10);
        chk("wrap_dig1", int'(dig1), 10);
`endif
        calc_timed("diff7", 10, 7);

        // Bouncy key3 press and release: one increment only
        key3 = 1'b0; repeat (2) tick();
        key3 = 1'b1; repeat (1) tick();
        key3 = 1'b0; repeat (2) tick();
        repeat (10) tick();
        chk("bounce_press", int'(dig6), 8);
        key3 = 1'b1; repeat (2) tick();
        key3 = 1'b0; repeat (1) tick();
        key3 = 1'b1; repeat (2) tick();
        repeat (10) tick();
        chk("bounce_release", int'(dig6), 8);

        // A wraps 9 -> 0
        press_key(3);
        chk("a9", int'(dig6), 9);
        press_key(3);
        chk("a_wrap", int'(dig6), 0);
        calc_timed("zero", 10, 0);

        // key2 press in SHOW
        press_key(2);
        chk("show_b_inc", int'(dig4), 1);
`ifdef CALC_LIVE_UPDATE_EN
        chk("show_key2_state", int'(state_o), 2);
        chk("show_key2_dig2", int'(dig2), 11);
        chk("show_key2_dig1", int'(dig1), 1);
`else
        chk("show_key2_state", int'(state_o), 0);
        chk("show_key2_dig2", int'(dig2), 10);
        chk("show_key2_dig1", int'(dig1), 10);
`endif

        // Reset during CALC with key0 held low
        key0 = 1'b0;
        repeat (7) tick();
        chk("hold_calc_state", int'(state_o), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        d0  = done_cnt;
        chk("rcalc_state", int'(state_o), 0);
        chk("rcalc_dig2", int'(dig2), 10);
        chk("rcalc_dig1", int'(dig1), 10);
        chk("rcalc_dig4", int'(dig4), 0);
        chk("rcalc_done", int'(done), 0);
        repeat (20) tick();
        chk("held_no_calc", int'(state_o), 0);
        key0 = 1'b1;
        repeat (12) tick();
        chk("released_no_calc", int'(state_o), 0);
        chk("held_no_done", done_cnt - d0, 0);
        calc_timed("repress", 10, 0);

`ifdef CALC_LIVE_UPDATE_EN
        // Live recompute on cal change and operand press
        rst = 1'b1;
        cal = 1'b1;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        repeat (3) press_key(3);
        repeat (3) press_key(2);
        calc_timed("live_sum6", 10, 6);
        d0  = done_cnt;
        cal = 1'b0;
        repeat (8) tick();
        chk("live_cal_dig2", int'(dig2), 10);
        chk("live_cal_dig1", int'(dig1), 0);
        chk("live_cal_done", done_cnt - d0, 1);
        press_key(3);
        chk("live_a4", int'(dig6), 4);
        chk("live_key3_dig2", int'(dig2), 10);
        chk("live_key3_dig1", int'(dig1), 1);
        chk("live_key3_state", int'(state_o), 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
